// File: rtl/aeolus_pkg.sv
// Shared definitions for the aeolus boot path: stream sync marker and
// the program loader's state encoding.
package aeolus_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    HUNT  = 4'd1,
    LEN   = 4'd2,
    DATA  = 4'd3,
    WR_HI = 4'd4,
    WR_LO = 4'd5,
    CHK   = 4'd6,
    DONE  = 4'd7,
    ERR   = 4'd8
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Receives a framed opcode stream (SYNC, N, packed nibbles, XOR checksum),
// writes one opcode per mem_we pulse and holds the CPU until the load is good.
module program_loader
  import aeolus_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4   // two opcodes per stream byte; only 4 is meaningful
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [OPCODE_WIDTH-1:0] mem_wdata,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    err,
  output logic [7:0]              loaded_len,
  output loader_state_t           state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid or start.

  loader_state_t           state_next;
  logic [ADDR_WIDTH-1:0]   addr, addr_next;
  logic [7:0]              remaining, remaining_next;
  logic [7:0]              byte_q, byte_next;
  logic [7:0]              csum, csum_next;
  logic [7:0]              len_next;
  logic                    accept;

  assign in_ready = (state == HUNT) || (state == LEN) || (state == DATA) || (state == CHK);
  assign accept   = in_valid && in_ready;
  assign mem_we   = (state == WR_HI) || (state == WR_LO);
  assign mem_addr = addr;
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign cpu_hold = (state != DONE);

  always_comb begin
    mem_wdata = '0;
    if (state == WR_HI) mem_wdata = byte_q[7:4];
    else if (state == WR_LO) mem_wdata = byte_q[3:0];
  end

  always_comb begin
    state_next     = state;
    addr_next      = addr;
    remaining_next = remaining;
    byte_next      = byte_q;
    csum_next      = csum;
    len_next       = loaded_len;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next = HUNT;
          addr_next  = '0;
          csum_next  = '0;
        end
      end
      HUNT: begin
        if (accept && in_data == SYNC_BYTE) state_next = LEN;
      end
      LEN: begin
        if (accept) begin
          if (in_data == 8'd0) begin
            state_next = ERR;
          end else begin
            len_next       = in_data;
            remaining_next = in_data;
            state_next     = DATA;
          end
        end
      end
      DATA: begin
        // The whole byte enters the checksum even if its low nibble is never written.
        if (accept) begin
          byte_next  = in_data;
          csum_next  = csum ^ in_data;
          state_next = WR_HI;
        end
      end
      WR_HI: begin
        addr_next      = addr + ADDR_WIDTH'(1);
        remaining_next = remaining - 8'd1;
        state_next     = (remaining != 8'd1) ? WR_LO : CHK;
      end
      WR_LO: begin
        addr_next      = addr + ADDR_WIDTH'(1);
        remaining_next = remaining - 8'd1;
        state_next     = (remaining != 8'd1) ? DATA : CHK;
      end
      CHK: begin
        if (accept) state_next = (in_data == csum) ? DONE : ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      byte_q     <= '0;
      csum       <= '0;
      loaded_len <= '0;
    end else begin
      state      <= state_next;
      addr       <= addr_next;
      remaining  <= remaining_next;
      byte_q     <= byte_next;
      csum       <= csum_next;
      loaded_len <= len_next;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the requirements
// plus randomized frames with backpressure, checked against a frame-parsing model.
module tb_program_loader;
  import aeolus_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [7:0]    mem_addr;
  logic [3:0]    mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [7:0]    loaded_len;
  loader_state_t state;

  program_loader #(.ADDR_WIDTH(8), .OPCODE_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .loaded_len(loaded_len), .state(state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          stall_pct = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [7:0]  frame_q[$];
  logic        exp_done, exp_err;
  logic [7:0]  exp_len;
  logic [7:0]  prev_len = 8'h00;

  // Write monitor: every strobe observed becomes one {addr, opcode} record.
  always @(negedge clk) if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});

  // Reference model: parse frame_q as a byte stream and list the writes it implies.
  task automatic model_frame();
    int i = 0;
    int n, nb;
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    logic [3:0] ops[$];
    exp_q.delete();
    while (frame_q[i] != SYNC_BYTE) i++;
    n = int'(frame_q[i+1]);
    if (n == 0) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_len = prev_len;
      return;
    end
    nb = (n + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      b = frame_q[i+2+k];
      x = x ^ b;
      ops.push_back(b[7:4]);
      ops.push_back(b[3:0]);
    end
    for (int k = 0; k < n; k++) exp_q.push_back({8'(k), ops[k]});
    exp_done = (x == frame_q[i+2+nb]);
    exp_err  = !exp_done;
    exp_len  = 8'(n);
    prev_len = 8'(n);
  endtask

  function automatic bit writes_match();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[k]) if (got_q[k] !== exp_q[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    got_q.delete();
  endtask

  // Drives one byte until accepted; stalls and stray start pulses are sprinkled in.
  task automatic send_byte(input logic [7:0] b);
    int  waited = 0;
    bit  acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) < stall_pct) begin
        in_valid = 1'b0; in_data = 8'($urandom);
      end else begin
        in_valid = 1'b1; in_data = b; acc = in_ready;
      end
      waited++;
      if (!acc && waited > 300) begin
        $display("FAIL send_byte_timeout byte=%h state=%s", b, state.name());
        checks++; errors++;
        return;
      end
    end
  endtask

  task automatic send_frame();
    foreach (frame_q[k]) send_byte(frame_q[k]);
    @(negedge clk); in_valid = 1'b0; start = 1'b0;
    for (int c = 0; c < 30 && !(done || err); c++) @(negedge clk);
    if (!(done || err)) begin
      $display("FAIL frame_end_timeout state=%s", state.name());
      checks++; errors++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = SYNC_BYTE;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== IDLE || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      $display("FAIL reset_ctrl state=%s in_ready=%b mem_we=%b expected IDLE 0 0", state.name(), in_ready, mem_we);
      errors++;
    end
    checks++;
    if ({mem_addr, mem_wdata, cpu_hold, done, err, loaded_len} !== {8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      $display("FAIL reset_outputs addr=%h wdata=%h hold=%b done=%b err=%b len=%h expected 00 0 1 0 0 00",
               mem_addr, mem_wdata, cpu_hold, done, err, loaded_len);
      errors++;
    end
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    prev_len = 8'h00;
  endtask

  task automatic test_same_cycle_start();
    @(negedge clk); start = 1'b1; in_valid = 1'b1; in_data = SYNC_BYTE;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL idle_in_ready got=%b expected 0", in_ready); errors++;
    end
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    checks++;
    if (state !== HUNT || cpu_hold !== 1'b1) begin
      $display("FAIL start_same_cycle state=%s hold=%b expected HUNT 1", state.name(), cpu_hold); errors++;
    end
  endtask

  task automatic test_nominal();
    stall_pct = 0;
    do_start();
    frame_q = '{8'hA5, 8'h03, 8'h12, 8'h30, 8'h22};
    model_frame();
    send_frame();
    checks++;
    if (!writes_match()) begin
      $display("FAIL nominal_writes got_n=%0d expected_n=%0d", got_q.size(), exp_q.size()); errors++;
    end
    checks++;
    if ({done, err, cpu_hold, loaded_len} !== {exp_done, exp_err, !exp_done, exp_len}) begin
      $display("FAIL nominal_status done=%b err=%b hold=%b len=%h expected %b %b %b %h",
               done, err, cpu_hold, loaded_len, exp_done, exp_err, !exp_done, exp_len); errors++;
    end
  endtask

  task automatic test_hunt();
    stall_pct = 0;
    do_start();
    frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h9C, 8'h9C};
    model_frame();
    send_frame();
    checks++;
    if (!writes_match()) begin
      $display("FAIL hunt_writes got_n=%0d expected_n=%0d", got_q.size(), exp_q.size()); errors++;
    end
    checks++;
    if ({done, err, cpu_hold} !== 3'b100) begin
      $display("FAIL hunt_status done=%b err=%b hold=%b expected 1 0 0", done, err, cpu_hold); errors++;
    end
  endtask

  task automatic test_bad_checksum();
    stall_pct = 0;
    do_start();
    frame_q = '{8'hA5, 8'h02, 8'h9C, 8'h00};
    model_frame();
    send_frame();
    checks++;
    if (!writes_match()) begin
      $display("FAIL badchk_writes got_n=%0d expected_n=%0d", got_q.size(), exp_q.size()); errors++;
    end
    checks++;
    if ({done, err, cpu_hold} !== 3'b011) begin
      $display("FAIL badchk_status done=%b err=%b hold=%b expected 0 1 1", done, err, cpu_hold); errors++;
    end
  endtask

  task automatic test_zero_length();
    stall_pct = 0;
    do_start();
    frame_q = '{8'hA5, 8'h00};
    model_frame();
    send_frame();
    checks++;
    if (got_q.size() != 0 || {done, err, cpu_hold, loaded_len} !== {2'b01, 1'b1, exp_len}) begin
      $display("FAIL zero_len writes=%0d done=%b err=%b hold=%b len=%h expected 0 0 1 1 %h",
               got_q.size(), done, err, cpu_hold, loaded_len, exp_len); errors++;
    end
    do_start();
    frame_q = '{8'hA5, 8'h03, 8'h12, 8'h30, 8'h22};
    model_frame();
    send_frame();
    checks++;
    if (!writes_match() || {done, err, loaded_len} !== {2'b10, 8'h03}) begin
      $display("FAIL zero_len_recover writes=%0d done=%b err=%b len=%h expected 3 1 0 03",
               got_q.size(), done, err, loaded_len); errors++;
    end
  endtask

  task automatic test_random_frames();
    int n;
    logic [7:0] x, b;
    stall_pct = 40;
    for (int t = 0; t < 8; t++) begin
      n = (t == 0) ? 1 : (t == 1) ? 255 : (t == 2) ? 2 : $urandom_range(1, 255);
      frame_q.delete();
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        b = 8'($urandom);
        frame_q.push_back((b == SYNC_BYTE) ? 8'h5A : b);
      end
      frame_q.push_back(SYNC_BYTE);
      frame_q.push_back(8'(n));
      x = 8'h00;
      for (int k = 0; k < (n + 1) / 2; k++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        x = x ^ b;
      end
      if ($urandom_range(0, 3) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
      frame_q.push_back(x);
      do_start();
      model_frame();
      send_frame();
      checks++;
      if (!writes_match()) begin
        $display("FAIL random_writes frame=%0d n=%0d got_n=%0d expected_n=%0d", t, n, got_q.size(), exp_q.size());
        errors++;
      end
      checks++;
      if ({done, err, cpu_hold, loaded_len} !== {exp_done, exp_err, !exp_done, exp_len}) begin
        $display("FAIL random_status frame=%0d done=%b err=%b hold=%b len=%h expected %b %b %b %h",
                 t, done, err, cpu_hold, loaded_len, exp_done, exp_err, !exp_done, exp_len);
        errors++;
      end
    end
  endtask

  task automatic test_stall_reset();
    int seen;
    stall_pct = 50;
    do_start();
    frame_q = '{8'hA5, 8'h03, 8'h12, 8'h30, 8'h22};
    model_frame();
    send_frame();
    checks++;
    if (!writes_match() || done !== 1'b1) begin
      $display("FAIL stall_nominal writes=%0d done=%b expected 3 1", got_q.size(), done); errors++;
    end
    do_start();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h12);
    @(negedge clk); in_valid = 1'b0; start = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 4'h1) begin
      $display("FAIL first_write we=%b addr=%h data=%h expected 1 00 1", mem_we, mem_addr, mem_wdata); errors++;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (state !== IDLE || cpu_hold !== 1'b1 || loaded_len !== 8'h00) begin
      $display("FAIL mid_reset state=%s hold=%b len=%h expected IDLE 1 00", state.name(), cpu_hold, loaded_len);
      errors++;
    end
    seen = got_q.size();
    repeat (10) @(negedge clk);
    checks++;
    if (seen != 1 || got_q.size() != 1 || got_q[0] !== 12'h001) begin
      $display("FAIL post_reset_writes got=%0d expected 1 (00,1)", got_q.size()); errors++;
    end
    prev_len = 8'h00;
  endtask

  initial begin
    test_reset();
    test_same_cycle_start();
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    test_nominal();
    test_hunt();
    test_bad_checksum();
    test_zero_length();
    test_random_frames();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog state=%s", state.name());
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the program-memory address width (opcode slots = 2^ADDR_WIDTH).
REQ-002 Parameter OPCODE_WIDTH, default 4, SHALL set the stored opcode width; only the value 4 (two opcodes per byte) is supported.
REQ-003 Port clk, input, 1, SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the synchronous, active-low reset.
REQ-005 Port start, input, 1: SHALL be a load-request pulse.
REQ-006 Port in_data, input, 8: SHALL carry the stream byte.
REQ-007 Port in_valid, input, 1: SHALL mark in_data as valid.
REQ-008 Port in_ready, output, 1: SHALL indicate the loader accepts a byte; a transfer SHALL occur only when in_valid and in_ready are both high.
REQ-009 Port mem_we, output, 1: SHALL be the program-memory write strobe.
REQ-010 Port mem_addr, output, ADDR_WIDTH: SHALL be the write address.
REQ-011 Port mem_wdata, output, 4: SHALL be the opcode being written.
REQ-012 Port cpu_hold, output, 1: SHALL hold the CPU in reset while high.
REQ-013 Port done, output, 1: SHALL indicate a successful load.
REQ-014 Port err, output, 1: SHALL indicate a failed load.
REQ-015 Port loaded_len, output, 8: SHALL report the opcode count of the last frame.

Function
REQ-016 Frame format SHALL be: SYNC byte 0xA5, length N (opcodes, 1..255), ceil(N/2) payload bytes (high nibble first), checksum byte equal to the XOR of all payload bytes.
REQ-017 The FSM SHALL have the states IDLE, HUNT, LEN, DATA, WR_HI, WR_LO, CHK, DONE and ERR.
REQ-018 start in IDLE, DONE or ERR SHALL move the FSM to HUNT on the next cycle, clear done/err, set cpu_hold, zero the address and the checksum accumulator.
REQ-019 start in any other state SHALL be ignored.
REQ-020 in_ready SHALL be high only in HUNT, LEN, DATA and CHK, and SHALL be low in IDLE, so a same-cycle start+in_valid accepts no byte.
REQ-021 HUNT: an accepted byte other than 0xA5 SHALL be discarded with the FSM staying in HUNT; 0xA5 SHALL move it to LEN.
REQ-022 LEN: N=0 SHALL move the FSM to ERR; otherwise it SHALL latch N into loaded_len and a remaining counter, and go to DATA.
REQ-023 DATA: the accepted byte SHALL be registered, XORed into the checksum, and the FSM SHALL go to WR_HI.
REQ-024 WR_HI SHALL issue one cycle of mem_we=1, mem_addr=addr, mem_wdata=byte[7:4]; then addr+1, remaining-1; the FSM SHALL go to WR_LO if remaining>0, else to CHK.
REQ-025 WR_LO SHALL write byte[3:0] the same way; the FSM SHALL go to DATA if remaining>0, else to CHK.
REQ-026 For odd N, the low nibble of the last byte SHALL NOT be written but SHALL be included in the checksum.
REQ-027 Each opcode SHALL produce exactly one mem_we pulse; addresses SHALL run 0..N-1, and the address SHALL never wrap within a frame since N≤255.
REQ-028 CHK: a match SHALL move the FSM to DONE (done=1, cpu_hold=0) on the cycle after acceptance; a mismatch SHALL move it to ERR (err=1, cpu_hold=1).
REQ-029 Backpressure SHALL be tolerated: in_valid low SHALL stall any input state indefinitely with no write.
REQ-030 mem_we SHALL be 0 in all states other than WR_HI and WR_LO.

Reset
REQ-031 With reset low at a clock edge, the block SHALL enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0 and loaded_len=0.
REQ-032 Reset mid-load SHALL abort with no further mem_we; memory already written SHALL remain unchanged.
REQ-033 Reset SHALL take priority over start and over any handshake.

Structure
REQ-034 SYNC_BYTE (0xA5) and the FSM state encoding SHALL reside in the shared package aeolus_pkg.
REQ-035 The block SHALL be a single module with no sub-module; the checksum and counters SHALL be inline registers.

Verification
REQ-036 Nominal test: start, then A5 03 12 30 22 SHALL produce writes (0,1),(1,2),(2,3), no write to address 3, then done=1, cpu_hold=0, loaded_len=3.
REQ-037 Hunt test: start, then 00 FF A5 02 9C 9C SHALL produce writes (0,9),(1,C) and done=1, with 00 and FF ignored.
REQ-038 Bad checksum: start, then A5 02 9C 00 SHALL produce two writes followed by err=1, cpu_hold=1, done=0.
REQ-039 Zero length: start, then A5 00 SHALL give err=1 with no mem_we; a later start followed by a valid frame SHALL clear err and give done=1.
REQ-040 Stall and reset test: in_valid toggled randomly during the nominal frame SHALL yield identical writes; reset driven low after the first write SHALL give IDLE, cpu_hold=1 and no further mem_we.
